uart_tx_arbiter: RTL and testbench

- Shares one UART transmit line between NUM_REQ byte requesters, e.g. CPU console and debug monitor.
- Arbitrates round-robin and supports an optional lock, so a multi-byte message from one requester is never interleaved with another's.
- Serializes 8N1 frames itself, timed by the txclk_en bit-period strobe from the baud rate generator.
- Sits between requester logic and the board TX pin.

---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-requester lock that shares one 8N1 UART transmit line.
// state | meaning: IDLE = arbitrate/accept, START = start bit, DATA = bits 0..7 LSB first, STOP = stop bit, sample lock
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 txclk_en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_lock,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [NUM_REQ-1:0]   grant
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic                 lock_q, lock_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ready_d;

    logic                 found;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W-1:0]     cand;
    logic                 acc_en;
    logic [IDX_W-1:0]     acc_idx;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First valid requester searching upward from the slot after the last winner
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        cand  = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        lock_d    = lock_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        grant_d   = grant_q;
        ready_d   = '0;
        acc_en    = 1'b0;
        acc_idx   = sel;

        case (state_q)
            IDLE: begin
                if (lock_q && req_lock[owner_q]) begin
                    grant_d = onehot(owner_q);
                    if (req_valid[owner_q]) begin
                        acc_en  = 1'b1;
                        acc_idx = owner_q;
                    end
                end else begin
                    // A released lock falls through to normal arbitration in the same cycle
                    lock_d = 1'b0;
                    if (found) begin
                        acc_en  = 1'b1;
                        acc_idx = sel;
                    end else begin
                        grant_d = '0;
                    end
                end
            end
            START: begin
                if (txclk_en) begin
                    tx_d      = 1'b0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (txclk_en) begin
                    tx_d      = shift_q[bit_idx_q];
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (txclk_en) begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                    lock_d  = req_lock[owner_q];
                    grant_d = req_lock[owner_q] ? onehot(owner_q) : '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (acc_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_idx == IDX_W'(i)) begin
                    shift_d = req_data[8*i +: 8];
                end
            end
            ready_d  = onehot(acc_idx);
            owner_d  = acc_idx;
            ptr_d    = acc_idx;
            grant_d  = onehot(acc_idx);
            state_d  = START;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_RESET;
            owner_q   <= '0;
            lock_q    <= 1'b0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            lock_q    <= lock_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            grant_q   <= grant_d;
        end
    end

    // Accept strobe is combinational; gate it so reset silences it immediately
    assign req_ready = rst_n ? ready_d : '0;
    assign tx        = tx_q;
    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: queue-driven requesters, strobe-sampled UART receiver, round-robin/lock reference model.
module tb_uart_tx_arbiter;
    localparam int N = 2;

    logic           clk_50m = 1'b0;
    logic           rst_n = 1'b0;
    logic           txclk_en = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_lock = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx;
    logic           busy;
    logic [N-1:0]   grant;

    uart_tx_arbiter #(.NUM_REQ(N), .IDX_W(1)) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .txclk_en (txclk_en),
        .req_valid(req_valid),
        .req_lock (req_lock),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx       (tx),
        .busy     (busy),
        .grant    (grant)
    );

    always #10 clk_50m = ~clk_50m;

    int checks = 0;
    int passed = 0;

    // requester side: each entry is {lock, byte}
    logic [8:0] pend [N][$];
    bit         sync_gate [N];
    bit         lock_upd [N];
    logic       lock_new [N];
    int         acc_cnt [N];
    int         acc_log [$];
    int         proto_err = 0;
    int         per = 4;
    int         scnt = 0;

    // receiver side
    int         rx_st = 0;
    logic [7:0] rx_sh;
    logic [N-1:0] rx_g;
    int         gap = 0;
    logic [7:0] rx_bytes [$];
    logic [N-1:0] rx_grants [$];
    int         rx_gaps [$];
    logic       slog [$];
    logic       sbusy [$];
    int         frame_err = 0;
    int         glitch = 0;
    logic       prev_tx = 1'b1;

    initial begin
        forever begin
            @(negedge clk_50m);
            for (int i = 0; i < N; i++) begin
                if (lock_upd[i]) begin
                    req_lock[i] = lock_new[i];
                    lock_upd[i] = 1'b0;
                end
            end
            txclk_en = (scnt == 0);
            scnt = (scnt + 1 >= per) ? 0 : scnt + 1;
            for (int i = 0; i < N; i++) begin
                if (pend[i].size() > 0 && (req_valid[i] || !sync_gate[i] || txclk_en)) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = pend[i][0][7:0];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            #1;
            if (rst_n) begin
                if ($countones(req_ready) > 1 || (req_ready != '0 && busy)) proto_err++;
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i] && pend[i].size() > 0) begin
                        lock_new[i] = pend[i][0][8];
                        lock_upd[i] = 1'b1;
                        void'(pend[i].pop_front());
                        acc_cnt[i]++;
                        acc_log.push_back(i);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_50m);
            if (rst_n && txclk_en) begin
                #1;
                if (rx_st != 0 || tx == 1'b0) begin
                    slog.push_back(tx);
                    sbusy.push_back(busy);
                end
                if (rx_st == 0) begin
                    if (tx == 1'b0) begin
                        rx_st = 1;
                        rx_g = grant;
                        rx_gaps.push_back(gap);
                        gap = 0;
                    end else begin
                        gap++;
                    end
                end else if (rx_st <= 8) begin
                    rx_sh[rx_st-1] = tx;
                    rx_st++;
                end else begin
                    if (tx !== 1'b1) frame_err++;
                    else begin
                        rx_bytes.push_back(rx_sh);
                        rx_grants.push_back(rx_g);
                    end
                    rx_st = 0;
                    gap = 0;
                end
            end
        end
    end

    initial begin
        logic en_s, r_s;
        forever begin
            @(posedge clk_50m);
            en_s = txclk_en;
            r_s = rst_n;
            #1;
            if (r_s && rst_n && !en_s && tx !== prev_tx) glitch++;
            prev_tx = tx;
        end
    end

    task automatic clear_logs();
        rx_st = 0; gap = 0; frame_err = 0; glitch = 0; proto_err = 0;
        rx_bytes.delete(); rx_grants.delete(); rx_gaps.delete();
        slog.delete(); sbusy.delete(); acc_log.delete();
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    endtask

    task automatic set_per(input int p);
        per = p;
        scnt = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk_50m); #3;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i].delete();
            lock_upd[i] = 1'b0;
            sync_gate[i] = 1'b0;
        end
        req_lock = '0;
        repeat (2) @(negedge clk_50m);
        #3;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (rx_bytes.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_50m); #3;
        end
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk_50m);
        #3;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || grant !== 2'b00 || req_ready !== 2'b00)
            $display("FAIL reset_hold: tx=%b busy=%b grant=%b ready=%b, want 1 0 00 00", tx, busy, grant, req_ready);
        else passed++;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_50m); #3;
            if (tx !== 1'b1 || busy !== 1'b0 || grant !== 2'b00 || req_ready !== 2'b00) bad++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || grant !== 2'b00 || req_ready !== 2'b00)
            $display("FAIL reset_mididle: tx=%b busy=%b grant=%b ready=%b, want 1 0 00 00", tx, busy, grant, req_ready);
        else passed++;
        @(negedge clk_50m); #3;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_50m); #3;
            if (tx !== 1'b1 || busy !== 1'b0 || grant !== 2'b00 || req_ready !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL idle_quiet: %0d active cycles, want 0", bad);
        else passed++;
        clear_logs();
    endtask

    task automatic test_single();
        bit ok;
        logic [9:0] exp_lv;
        set_per(4);
        clear_logs();
        pend[0].push_back({1'b0, 8'h55});
        wait_rx(1, 200, ok);
        repeat (3) @(negedge clk_50m);
        #3;
        checks++;
        if (!ok) $display("FAIL single_timeout: got %0d bytes, want 1", rx_bytes.size());
        else passed++;
        checks++;
        if (acc_cnt[0] != 1 || acc_cnt[1] != 0)
            $display("FAIL single_ready: accepts r0=%0d r1=%0d, want 1 0", acc_cnt[0], acc_cnt[1]);
        else passed++;
        exp_lv = 10'b1_01010101_0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= slog.size() || slog[i] !== exp_lv[i])
                $display("FAIL single_level[%0d]: got %b, want %b", i, (i < slog.size()) ? slog[i] : 1'bx, exp_lv[i]);
            else passed++;
        end
        checks++;
        if (sbusy.size() < 10 || sbusy[8] !== 1'b1 || sbusy[9] !== 1'b0)
            $display("FAIL single_busy_fall: size=%0d, want busy 1 then 0 at stop strobe", sbusy.size());
        else passed++;
        checks++;
        if (glitch != 0 || proto_err != 0)
            $display("FAIL single_timing: glitches=%0d proto=%0d, want 0 0", glitch, proto_err);
        else passed++;
    endtask

    task automatic test_alternate();
        bit ok;
        logic [7:0] eb [4];
        logic [N-1:0] eg [4];
        apply_reset();
        set_per(4);
        eb = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
        eg = '{2'b01, 2'b10, 2'b01, 2'b10};
        pend[0].push_back({1'b0, 8'hA1}); pend[0].push_back({1'b0, 8'hA1});
        pend[1].push_back({1'b0, 8'hB2}); pend[1].push_back({1'b0, 8'hB2});
        wait_rx(4, 400, ok);
        checks++;
        if (!ok) $display("FAIL alt_timeout: got %0d bytes, want 4", rx_bytes.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= rx_bytes.size() || rx_bytes[i] !== eb[i] || rx_grants[i] !== eg[i])
                $display("FAIL alt_frame[%0d]: byte=%h grant=%b, want %h %b", i,
                         (i < rx_bytes.size()) ? rx_bytes[i] : 8'hxx, (i < rx_grants.size()) ? rx_grants[i] : 2'bxx, eb[i], eg[i]);
            else passed++;
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (i >= rx_gaps.size() || rx_gaps[i] != 0)
                $display("FAIL alt_gap[%0d]: got %0d idle strobes, want 0", i, (i < rx_gaps.size()) ? rx_gaps[i] : -1);
            else passed++;
        end
        checks++;
        if (frame_err != 0 || glitch != 0 || proto_err != 0)
            $display("FAIL alt_errors: frame=%0d glitch=%0d proto=%0d, want 0 0 0", frame_err, glitch, proto_err);
        else passed++;
    endtask

    task automatic test_lock();
        bit ok;
        int bad;
        logic [7:0] eb [5];
        int eo [5];
        set_per(3);
        clear_logs();
        eb = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21};
        eo = '{1, 1, 1, 0, 0};
        pend[1].push_back({1'b1, 8'h10});
        pend[1].push_back({1'b1, 8'h11});
        pend[1].push_back({1'b0, 8'h12});
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk_50m); #3;
            ok = (acc_cnt[1] > 0);
        end
        checks++;
        if (!ok) $display("FAIL lock_first_accept: req1 accepts=%0d, want 1", acc_cnt[1]);
        else passed++;
        pend[0].push_back({1'b0, 8'h20});
        pend[0].push_back({1'b0, 8'h21});
        bad = 0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_50m); #3;
            if (rx_bytes.size() >= 3) begin
                ok = 1'b1;
                break;
            end
            if (grant !== 2'b10) bad++;
        end
        checks++;
        if (!ok || bad != 0) $display("FAIL lock_grant_held: ok=%0d cycles_not_10=%0d, want 1 0", ok, bad);
        else passed++;
        wait_rx(5, 300, ok);
        checks++;
        if (!ok) $display("FAIL lock_timeout: got %0d bytes, want 5", rx_bytes.size());
        else passed++;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= rx_bytes.size() || i >= acc_log.size() || rx_bytes[i] !== eb[i] || acc_log[i] != eo[i]
                || rx_grants[i] !== (2'b01 << eo[i]))
                $display("FAIL lock_frame[%0d]: byte=%h owner=%0d, want %h %0d", i,
                         (i < rx_bytes.size()) ? rx_bytes[i] : 8'hxx, (i < acc_log.size()) ? acc_log[i] : -1, eb[i], eo[i]);
            else passed++;
        end
        checks++;
        if (rx_gaps.size() < 3 || rx_gaps[1] != 0 || rx_gaps[2] != 0)
            $display("FAIL lock_contiguous: gaps not zero between locked frames");
        else passed++;
    endtask

    task automatic test_accept_strobe();
        bit ok;
        int ones, zeros, phase;
        set_per(4);
        clear_logs();
        sync_gate[1] = 1'b1;
        pend[1].push_back({1'b0, 8'hA5});
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk_50m); #3;
            ok = (acc_cnt[1] > 0);
        end
        checks++;
        if (!ok) $display("FAIL strobe_accept: req1 accepts=%0d, want 1", acc_cnt[1]);
        else passed++;
        ones = 0; zeros = 0; phase = 0;
        for (int c = 0; c < 40 && phase < 2; c++) begin
            @(negedge clk_50m); #3;
            if (phase == 0) begin
                if (tx === 1'b1) ones++;
                else begin phase = 1; zeros = 1; end
            end else begin
                if (tx === 1'b0) zeros++;
                else phase = 2;
            end
        end
        checks++;
        if (ones != 4) $display("FAIL strobe_delay: tx high %0d clocks after accept, want 4", ones);
        else passed++;
        checks++;
        if (zeros != 4) $display("FAIL strobe_startbit: start bit %0d clocks, want 4", zeros);
        else passed++;
        sync_gate[1] = 1'b0;
        wait_rx(1, 100, ok);
        checks++;
        if (!ok || rx_bytes[0] !== 8'hA5) $display("FAIL strobe_byte: got %0d bytes, want A5", rx_bytes.size());
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        set_per(4);
        clear_logs();
        pend[1].push_back({1'b0, 8'h6B});
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk_50m); #3;
            ok = (slog.size() >= 5);
        end
        @(negedge clk_50m); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || tx !== 1'b1 || busy !== 1'b0 || grant !== 2'b00)
            $display("FAIL midframe_reset: reached=%0d tx=%b busy=%b grant=%b, want 1 1 0 00", ok, tx, busy, grant);
        else passed++;
        for (int i = 0; i < N; i++) begin
            pend[i].delete();
            lock_upd[i] = 1'b0;
        end
        req_lock = '0;
        repeat (2) @(negedge clk_50m);
        #3;
        rst_n = 1'b1;
        clear_logs();
        pend[0].push_back({1'b0, 8'h3C});
        pend[1].push_back({1'b0, 8'h5A});
        wait_rx(2, 200, ok);
        checks++;
        if (!ok || acc_log.size() < 2 || acc_log[0] != 0 || rx_grants[0] !== 2'b01)
            $display("FAIL midframe_first_grant: ok=%0d first_owner=%0d, want 1 0", ok, (acc_log.size() > 0) ? acc_log[0] : -1);
        else passed++;
        checks++;
        if (rx_bytes.size() < 2 || rx_bytes[0] !== 8'h3C || rx_bytes[1] !== 8'h5A || frame_err != 0)
            $display("FAIL midframe_bytes: got %0d bytes frame_err=%0d, want 3C 5A", rx_bytes.size(), frame_err);
        else passed++;
    endtask

    task automatic test_random();
        bit ok;
        logic [8:0] mdl [N][$];
        logic [7:0] exp_b [$];
        int exp_o [$];
        int ptr, r, total, nmsg, len;
        logic [8:0] e;
        apply_reset();
        set_per($urandom_range(2, 5));
        for (int i = 0; i < N; i++) begin
            nmsg = $urandom_range(1, 3);
            for (int m = 0; m < nmsg; m++) begin
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) begin
                    e = {(b != len - 1), 8'($urandom_range(0, 255))};
                    pend[i].push_back(e);
                    mdl[i].push_back(e);
                end
            end
        end
        // whole messages go out in round-robin order, owner keeps the line until its message ends
        ptr = N - 1;
        total = 0;
        forever begin
            r = -1;
            for (int k = 1; k <= N; k++) begin
                if (r < 0 && mdl[(ptr + k) % N].size() > 0) r = (ptr + k) % N;
            end
            if (r < 0) break;
            do begin
                e = mdl[r].pop_front();
                exp_b.push_back(e[7:0]);
                exp_o.push_back(r);
                total++;
            end while (e[8] && mdl[r].size() > 0);
            ptr = r;
        end
        wait_rx(total, total * 12 * per + 100, ok);
        checks++;
        if (!ok) $display("FAIL rand_timeout: got %0d bytes, want %0d", rx_bytes.size(), total);
        else passed++;
        for (int i = 0; i < total; i++) begin
            checks++;
            if (i >= rx_bytes.size() || rx_bytes[i] !== exp_b[i] || rx_grants[i] !== (2'b01 << exp_o[i]))
                $display("FAIL rand_frame[%0d]: byte=%h grant=%b, want %h owner %0d", i,
                         (i < rx_bytes.size()) ? rx_bytes[i] : 8'hxx, (i < rx_grants.size()) ? rx_grants[i] : 2'bxx, exp_b[i], exp_o[i]);
            else passed++;
        end
        checks++;
        if (frame_err != 0 || glitch != 0 || proto_err != 0)
            $display("FAIL rand_errors: frame=%0d glitch=%0d proto=%0d, want 0 0 0", frame_err, glitch, proto_err);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            sync_gate[i] = 1'b0;
            lock_upd[i] = 1'b0;
            lock_new[i] = 1'b0;
            acc_cnt[i] = 0;
        end
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_accept_strobe();
        test_reset_mid_frame();
        test_random();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
